// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-requester AXI4 read-channel arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam logic [2:0] ARSIZE_4B    = 3'b010;
  localparam logic [1:0] ARBURST_INCR = 2'b01;

  localparam logic [3:0] DEF_I_ID = 4'd0;
  localparam logic [3:0] DEF_D_ID = 4'd1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the side not granted last.
module rr_arb2
  import axi_arb_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  owner_e     last_grant,
  output logic [1:0] gnt          // [0] icache, [1] dcache
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    gnt = 2'b00;
    if (req_i && req_d) begin
      gnt = (last_grant == OWN_I) ? 2'b10 : 2'b01;
    end else begin
      gnt = {req_d, req_i};
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read channel between icache and dcache, one burst outstanding at a time,
// with a sticky checker on burst length and returned ID.
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter logic [3:0] I_ID   = DEF_I_ID,
  parameter logic [3:0] D_ID   = DEF_D_ID
) (
  input  logic              clk,
  input  logic              rstn,

  input  logic              i_arvalid,
  input  logic [ADDR_W-1:0] i_araddr,
  input  logic [7:0]        i_arlen,
  output logic              i_arready,
  output logic              i_rvalid,
  output logic              i_rlast,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              i_rready,

  input  logic              d_arvalid,
  input  logic [ADDR_W-1:0] d_araddr,
  input  logic [7:0]        d_arlen,
  output logic              d_arready,
  output logic              d_rvalid,
  output logic              d_rlast,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              d_rready,

  output logic              m_arvalid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic [3:0]        m_arid,
  input  logic              m_arready,
  input  logic              m_rvalid,
  input  logic              m_rlast,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [3:0]        m_rid,
  output logic              m_rready,

  output logic              err
);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              last_grant_q, last_grant_d;
  logic                m_arvalid_q, m_arvalid_d;
  logic [ADDR_W-1:0]   m_araddr_q, m_araddr_d;
  logic [7:0]          m_arlen_q, m_arlen_d;
  logic [3:0]          m_arid_q, m_arid_d;
  logic [7:0]          beat_cnt_q, beat_cnt_d;
  logic                err_q, err_d;

  logic [1:0]          gnt;
  logic                in_ar, in_r, own_d, r_hs;
  logic [3:0]          owner_id;

  rr_arb2 u_rr_arb2 (
    .req_i      (i_arvalid),
    .req_d      (d_arvalid),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  assign in_ar    = (state_q == AR);
  assign in_r     = (state_q == R);
  assign own_d    = (owner_q == OWN_D);
  assign owner_id = own_d ? D_ID : I_ID;
  assign r_hs     = m_rvalid && m_rready;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    m_arvalid_d  = m_arvalid_q;
    m_araddr_d   = m_araddr_q;
    m_arlen_d    = m_arlen_q;
    m_arid_d     = m_arid_q;
    beat_cnt_d   = beat_cnt_q;
    err_d        = err_q;

    unique case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          owner_d     = gnt[1] ? OWN_D : OWN_I;
          m_araddr_d  = gnt[1] ? d_araddr : i_araddr;
          m_arlen_d   = gnt[1] ? d_arlen : i_arlen;
          m_arid_d    = gnt[1] ? D_ID : I_ID;
          m_arvalid_d = 1'b1;
          state_d     = AR;
        end
      end
      AR: begin
        if (m_arready) begin
          m_arvalid_d = 1'b0;
          beat_cnt_d  = 8'd0;
          state_d     = R;
        end
      end
      R: begin
        if (r_hs) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          // A bad burst is flagged, but only the slave's rlast ends ownership.
          if ((m_rlast && (beat_cnt_q != m_arlen_q)) ||
              (!m_rlast && (beat_cnt_q == m_arlen_q)) ||
              (m_rid != owner_id)) begin
            err_d = 1'b1;
          end
          if (m_rlast) begin
            last_grant_d = owner_q;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      last_grant_q <= OWN_I;
      m_arvalid_q  <= 1'b0;
      m_araddr_q   <= '0;
      m_arlen_q    <= '0;
      m_arid_q     <= '0;
      beat_cnt_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      m_arvalid_q  <= m_arvalid_d;
      m_araddr_q   <= m_araddr_d;
      m_arlen_q    <= m_arlen_d;
      m_arid_q     <= m_arid_d;
      beat_cnt_q   <= beat_cnt_d;
      err_q        <= err_d;
    end
  end

  assign m_arvalid = m_arvalid_q;
  assign m_araddr  = m_araddr_q;
  assign m_arlen   = m_arlen_q;
  assign m_arid    = m_arid_q;
  assign m_arsize  = ARSIZE_4B;
  assign m_arburst = ARBURST_INCR;
  assign err       = err_q;

  // Handshake and beat routing are combinational so the owner sees zero added latency.
  assign i_arready = in_ar && !own_d && m_arready;
  assign d_arready = in_ar &&  own_d && m_arready;
  assign i_rvalid  = in_r  && !own_d && m_rvalid;
  assign d_rvalid  = in_r  &&  own_d && m_rvalid;
  assign i_rlast   = in_r  && !own_d && m_rlast;
  assign d_rlast   = in_r  &&  own_d && m_rlast;
  assign i_rdata   = m_rdata;
  assign d_rdata   = m_rdata;
  assign m_rready  = in_r && (own_d ? d_rready : i_rready);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: stimulus queues expected AR/R traffic, a monitor checks it.
module tb_axi_rd_arbiter;
  import axi_arb_pkg::*;

  localparam logic [3:0] I_ID = 4'd0;
  localparam logic [3:0] D_ID = 4'd1;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_arvalid, d_arvalid, i_rready, d_rready;
  logic [31:0] i_araddr, d_araddr;
  logic [7:0]  i_arlen, d_arlen;
  logic        i_arready, d_arready, i_rvalid, d_rvalid, i_rlast, d_rlast;
  logic [31:0] i_rdata, d_rdata;
  logic        m_arvalid, m_arready, m_rvalid, m_rlast, m_rready, err;
  logic [31:0] m_araddr, m_rdata;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic [3:0]  m_arid, m_rid;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .I_ID(I_ID), .D_ID(D_ID)) dut (
    .clk(clk), .rstn(rstn),
    .i_arvalid(i_arvalid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arready(i_arready),
    .i_rvalid(i_rvalid), .i_rlast(i_rlast), .i_rdata(i_rdata), .i_rready(i_rready),
    .d_arvalid(d_arvalid), .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arready(d_arready),
    .d_rvalid(d_rvalid), .d_rlast(d_rlast), .d_rdata(d_rdata), .d_rready(d_rready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arid(m_arid), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rdata(m_rdata), .m_rid(m_rid),
    .m_rready(m_rready), .err(err)
  );

  typedef struct { logic own; logic [31:0] data; logic last; } beat_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; logic [3:0] id; } ar_t;

  beat_t r_q[$];
  ar_t   ar_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_beat(input logic own, input logic [31:0] data, input logic last);
    beat_t e;
    if (r_q.size() == 0) begin
      check("r_unexpected_beat", 1, 0);
    end else begin
      e = r_q.pop_front();
      check("r_owner", own, e.own);
      check("r_data", data, e.data);
      check("r_last", last, e.last);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a handshake.
  always @(negedge clk) begin : monitor
    ar_t e;
    if (rstn) begin
      if (i_arready || i_rvalid) check("i_arready_rvalid_excl", i_arready & i_rvalid, 0);
      if (d_arready || d_rvalid) check("d_arready_rvalid_excl", d_arready & d_rvalid, 0);
      if (m_arvalid && m_arready) begin
        if (ar_q.size() == 0) begin
          check("ar_unexpected", 1, 0);
        end else begin
          e = ar_q.pop_front();
          check("m_araddr", m_araddr, e.addr);
          check("m_arlen", m_arlen, e.len);
          check("m_arid", m_arid, e.id);
          check("m_arsize", m_arsize, 3'b010);
          check("m_arburst", m_arburst, 2'b01);
        end
      end
      if (i_rvalid && i_rready) pop_beat(1'b0, i_rdata, i_rlast);
      if (d_rvalid && d_rready) pop_beat(1'b1, d_rdata, d_rlast);
    end
  end

  task automatic do_reset();
    rstn = 1'b0;
    i_arvalid = 0; d_arvalid = 0; i_araddr = 0; d_araddr = 0; i_arlen = 0; d_arlen = 0;
    i_rready = 1; d_rready = 1; m_arready = 0; m_rvalid = 0; m_rlast = 0; m_rdata = 0; m_rid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {m_arvalid, m_araddr, m_arlen, m_arid, m_rready, i_arready, d_arready,
                            i_rvalid, d_rvalid, i_rlast, d_rlast, err}, 0);
    @(posedge clk); #1 rstn = 1'b1;
  endtask

  // Waits for m_arvalid, holds m_arready low, then accepts for exactly one cycle.
  task automatic do_ar(input logic own, input logic [31:0] addr, input logic [7:0] len,
                       input int low_cycles, input bit drop_mid);
    int t = 0;
    ar_q.push_back('{addr, len, own ? D_ID : I_ID});
    @(negedge clk);
    while (!m_arvalid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("ar_wait_timeout", m_arvalid, 1);
    for (int i = 0; i < low_cycles; i++) begin
      check("arready_while_stalled", {i_arready, d_arready}, 2'b00);
      check("araddr_stable", m_araddr, addr);
      check("arlen_stable", m_arlen, len);
      @(posedge clk); #1;
      if (drop_mid && i == 1) begin
        if (own) d_arvalid = 0; else i_arvalid = 0;
      end
      @(negedge clk);
    end
    @(posedge clk); #1 m_arready = 1;
    @(negedge clk);
    check("owner_arready", {i_arready, d_arready}, own ? 2'b01 : 2'b10);
    @(posedge clk); #1;
    m_arready = 0;
    if (own) d_arvalid = 0; else i_arvalid = 0;
  endtask

  task automatic send_beats(input logic own, input int n_sent, input int last_idx,
                            input logic [31:0] base, input logic [3:0] rid);
    for (int b = 0; b < n_sent; b++) begin
      m_rvalid = 1;
      m_rdata  = base + 32'(b);
      m_rlast  = (b == last_idx);
      m_rid    = rid;
      r_q.push_back('{own, base + 32'(b), (b == last_idx)});
      @(posedge clk); #1;
    end
    m_rvalid = 0;
    m_rlast  = 0;
  endtask

  task automatic after_burst(input logic exp_err);
    @(negedge clk);
    check("idle_m_rready", m_rready, 0);
    check("idle_m_arvalid", m_arvalid, 0);
    check("err_flag", err, exp_err);
  endtask

  initial begin : stimulus
    logic own;
    do_reset();

    // Icache alone, len=3.
    i_arvalid = 1; i_araddr = 32'h1C00_0040; i_arlen = 8'd3;
    do_ar(1'b0, 32'h1C00_0040, 8'd3, 0, 0);
    send_beats(1'b0, 4, 3, 32'hA000_0000, I_ID);
    after_burst(1'b0);

    // Tie straight out of reset: dcache first, icache after.
    do_reset();
    i_arvalid = 1; i_araddr = 32'h0000_1000; i_arlen = 8'd1;
    d_arvalid = 1; d_araddr = 32'h0000_2000; d_arlen = 8'd2;
    do_ar(1'b1, 32'h0000_2000, 8'd2, 0, 0);
    send_beats(1'b1, 3, 2, 32'hB000_0000, D_ID);
    after_burst(1'b0);
    do_ar(1'b0, 32'h0000_1000, 8'd1, 0, 0);
    send_beats(1'b0, 2, 1, 32'hB100_0000, I_ID);
    after_burst(1'b0);

    // Four back-to-back ties alternate D, I, D, I.
    for (int k = 0; k < 4; k++) begin
      own = (k % 2 == 0);
      i_arvalid = 1; i_araddr = 32'h3000_0000 + 32'(k * 16); i_arlen = 8'(k + 1);
      d_arvalid = 1; d_araddr = 32'h4000_0000 + 32'(k * 16); d_arlen = 8'(k);
      do_ar(own, own ? 32'h4000_0000 + 32'(k * 16) : 32'h3000_0000 + 32'(k * 16),
            own ? 8'(k) : 8'(k + 1), 0, 0);
      i_arvalid = 0; d_arvalid = 0;
      send_beats(own, own ? k + 1 : k + 2, own ? k : k + 1, 32'hC000_0000 + 32'(k * 256),
                 own ? D_ID : I_ID);
      after_burst(1'b0);
    end

    // Slave stalls AR; requester drops arvalid mid-stall.
    i_arvalid = 1; i_araddr = 32'h1C00_0100; i_arlen = 8'd2;
    do_ar(1'b0, 32'h1C00_0100, 8'd2, 5, 1);
    send_beats(1'b0, 3, 2, 32'hD000_0000, I_ID);
    after_burst(1'b0);

    // Early rlast on beat 2 of len=3; err stays set through a clean burst.
    i_arvalid = 1; i_araddr = 32'h1C00_0200; i_arlen = 8'd3;
    do_ar(1'b0, 32'h1C00_0200, 8'd3, 0, 0);
    send_beats(1'b0, 2, 1, 32'hE000_0000, I_ID);
    after_burst(1'b1);
    d_arvalid = 1; d_araddr = 32'h2000_0300; d_arlen = 8'd0;
    do_ar(1'b1, 32'h2000_0300, 8'd0, 0, 0);
    send_beats(1'b1, 1, 0, 32'hE100_0000, D_ID);
    after_burst(1'b1);
    do_reset();

    // Wrong rid on an icache burst.
    i_arvalid = 1; i_araddr = 32'h1C00_0400; i_arlen = 8'd1;
    do_ar(1'b0, 32'h1C00_0400, 8'd1, 0, 0);
    send_beats(1'b0, 2, 1, 32'hF000_0000, 4'd1);
    after_burst(1'b1);
    do_reset();

    // Reset after beat 2 of 4; stray beats afterwards must not be accepted.
    i_arvalid = 1; i_araddr = 32'h1C00_0500; i_arlen = 8'd3;
    do_ar(1'b0, 32'h1C00_0500, 8'd3, 0, 0);
    send_beats(1'b0, 2, 3, 32'h5000_0000, I_ID);
    m_rvalid = 1; m_rdata = 32'h5000_0002; m_rlast = 0; m_rid = I_ID;
    rstn = 0;
    @(negedge clk);
    check("midburst_reset_outputs", {m_arvalid, m_araddr, m_arlen, m_arid, m_rready, i_arready,
                                     d_arready, i_rvalid, d_rvalid, i_rlast, d_rlast, err}, 0);
    @(posedge clk); #1 rstn = 1;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      check("stray_beat_m_rready", m_rready, 0);
      check("stray_beat_i_rvalid", i_rvalid, 0);
      @(posedge clk); #1 m_rlast = (s == 0);
    end
    m_rvalid = 0; m_rlast = 0;
    d_arvalid = 1; d_araddr = 32'h2222_0000; d_arlen = 8'd0;
    do_ar(1'b1, 32'h2222_0000, 8'd0, 0, 0);
    send_beats(1'b1, 1, 0, 32'h6000_0000, D_ID);
    after_burst(1'b0);

    check("r_queue_drained", 64'(r_q.size()), 0);
    check("ar_queue_drained", 64'(ar_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
